// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage IF/ID/EX/MEM/WB core.
// Drives pc / pipeline-register enables and flushes, inserts one bubble on a
// load-use hazard, squashes wrong-path work on a redirect resolved in MEM,
// drains the pipe on HALT and keeps saturating stall / redirect counters.
module pipeline_ctrl #(
  parameter int          CNT_W     = 16,
  parameter logic [5:0]  HALT_OP   = 6'h3F,
  parameter int          DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [31:0]      instr_id,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_waddr,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Drain counter is loaded with DRAIN_CYC-1 so that DRAIN lasts DRAIN_CYC cycles.
  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYC - 1);

  state_t           state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic             hazard, redirect, halt_req;
  logic             unused_instr_bits;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A load writing $zero never creates a real dependency.
  assign hazard   = ex_mem_read & (ex_waddr != 5'd0) &
                    ((ex_waddr == instr_id[25:21]) |
                     (id_uses_rt & (ex_waddr == instr_id[20:16])));
  assign redirect = (mem_branch & mem_zero) | mem_jump;
  assign halt_req = (instr_id[31:26] == HALT_OP);

  assign unused_instr_bits = ^instr_id[15:0];

  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  // State and drain-counter registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      drain_q <= 2'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and same-cycle enable/flush decode; redirect outranks hazard outranks halt.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        id_ex_en = 1'b1;
        if (redirect) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
        end else if (hazard) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else if (halt_req) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = DRAIN;
          drain_d     = DRAIN_LOAD;
        end
        if (!enable) state_d = IDLE;
      end
      DRAIN: begin
        id_ex_en = 1'b1;
        if (redirect) begin
          // The branch is older than the halt, so execution resumes on its target.
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          state_d      = RUN;
          drain_d      = 2'd0;
        end else begin
          id_ex_flush = 1'b1;
          if (drain_q == 2'd0) state_d = HALTED;
          else                 drain_d = drain_q - 2'd1;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Performance counters, only stepped from RUN and cleared only by reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc) stall_q <= sat_inc(stall_q);
      if (flush_inc) flush_q <= sat_inc(flush_q);
    end
  end

endmodule
